// File: rtl/wb_pkg.sv
// Shared Wishbone arbiter types and bus widths.
package wb_pkg;
    localparam int WB_ADR_W = 16;
    localparam int WB_DAT_W = 16;

    typedef enum logic [1:0] {ARB_IDLE, ARB_GNT0, ARB_GNT1} arb_state_t;
endpackage

// File: rtl/wb_ack_tracker.sv
// Outstanding-transfer counter and ack timeout for the granted Wishbone master.
// Drops acks that arrive with nothing outstanding; issues a synthetic ack after TIMEOUT idle cycles.
module wb_ack_tracker #(
    parameter int MAX_OUT = 2,
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_accept,
    input  logic i_ack,
    output logic o_full,
    output logic o_real_ack,
    output logic o_syn_ack,
    output logic o_to_pulse,
    output logic o_to_sticky
);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] r_out;
    logic [TW-1:0] r_timer;
    logic          r_to_sticky;
    logic          w_busy;
    logic          w_any_ack;

    assign w_busy      = (r_out != '0);
    assign o_full      = (r_out == CW'(MAX_OUT));
    assign o_real_ack  = i_ack & w_busy & ~i_clr;
    // A real ack in the expiry cycle takes precedence over the synthetic one.
    assign o_syn_ack   = w_busy & ~i_clr & ~o_real_ack & (r_timer == TW'(TIMEOUT - 1));
    assign o_to_pulse  = o_syn_ack;
    assign o_to_sticky = r_to_sticky;
    assign w_any_ack   = o_real_ack | o_syn_ack;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out       <= '0;
            r_timer     <= '0;
            r_to_sticky <= 1'b0;
        end else begin
            if (o_syn_ack)
                r_to_sticky <= 1'b1;
            if (i_clr) begin
                r_out   <= '0;
                r_timer <= '0;
            end else begin
                if (i_accept && !w_any_ack)
                    r_out <= r_out + CW'(1);
                else if (!i_accept && w_any_ack)
                    r_out <= r_out - CW'(1);
                if (w_any_ack || !w_busy)
                    r_timer <= '0;
                else
                    r_timer <= r_timer + TW'(1);
            end
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter (whole CYC cycles) sharing one pipelined Wishbone port between CPU (m0) and USB DMA (m1).
// Grant registered one cycle after CYC; stb throttled at MAX_OUT outstanding; non-granted master sees stall=1.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int                  MAX_OUT      = 2,
    parameter int                  TIMEOUT      = 255,
    parameter logic [WB_DAT_W-1:0] TIMEOUT_DATA = 16'hFFFF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_m0_cyc,
    input  logic                i_m0_stb,
    input  logic                i_m0_we,
    input  logic [WB_ADR_W-1:0] i_m0_adr,
    input  logic [WB_DAT_W-1:0] i_m0_dat,
    output logic                o_m0_ack,
    output logic                o_m0_stall,
    output logic [WB_DAT_W-1:0] o_m0_dat,
    input  logic                i_m1_cyc,
    input  logic                i_m1_stb,
    input  logic                i_m1_we,
    input  logic [WB_ADR_W-1:0] i_m1_adr,
    input  logic [WB_DAT_W-1:0] i_m1_dat,
    output logic                o_m1_ack,
    output logic                o_m1_stall,
    output logic [WB_DAT_W-1:0] o_m1_dat,
    output logic                o_s_cyc,
    output logic                o_s_stb,
    output logic                o_s_we,
    output logic [WB_ADR_W-1:0] o_s_adr,
    output logic [WB_DAT_W-1:0] o_s_dat,
    input  logic                i_s_ack,
    input  logic                i_s_stall,
    input  logic [WB_DAT_W-1:0] i_s_dat,
    output logic [1:0]          o_gnt,
    output logic                o_to_pulse,
    output logic                o_to_sticky
);
    arb_state_t r_state;
    logic       r_last;   // 1: m1 held the most recent grant
    logic [1:0] r_gnt;

    logic                w_g0, w_g1;
    logic                w_cyc, w_stb;
    logic                w_full, w_real_ack, w_syn_ack, w_ack_m;
    logic [WB_DAT_W-1:0] w_dat_m;

    assign w_g0  = (r_state == ARB_GNT0);
    assign w_g1  = (r_state == ARB_GNT1);
    assign w_cyc = (w_g0 & i_m0_cyc) | (w_g1 & i_m1_cyc);
    assign w_stb = (w_g0 & i_m0_stb) | (w_g1 & i_m1_stb);

    // s.cyc follows the granted master combinationally so an abort releases the bus in the same cycle.
    assign o_s_cyc = w_cyc;
    assign o_s_stb = w_cyc & w_stb & ~w_full;
    assign o_s_we  = (w_g0 & i_m0_we) | (w_g1 & i_m1_we);
    assign o_s_adr = w_g0 ? i_m0_adr : (w_g1 ? i_m1_adr : '0);
    assign o_s_dat = w_g0 ? i_m0_dat : (w_g1 ? i_m1_dat : '0);

    assign w_ack_m = w_real_ack | w_syn_ack;
    assign w_dat_m = w_syn_ack ? TIMEOUT_DATA : i_s_dat;

    assign o_m0_ack   = w_g0 & w_ack_m;
    assign o_m0_stall = w_g0 ? (i_s_stall | w_full) : 1'b1;
    assign o_m0_dat   = w_g0 ? w_dat_m : '0;
    assign o_m1_ack   = w_g1 & w_ack_m;
    assign o_m1_stall = w_g1 ? (i_s_stall | w_full) : 1'b1;
    assign o_m1_dat   = w_g1 ? w_dat_m : '0;
    assign o_gnt      = r_gnt;

    wb_ack_tracker #(
        .MAX_OUT (MAX_OUT),
        .TIMEOUT (TIMEOUT)
    ) u_tracker (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clr       (~w_cyc),
        .i_accept    (o_s_stb & ~i_s_stall),
        .i_ack       (i_s_ack),
        .o_full      (w_full),
        .o_real_ack  (w_real_ack),
        .o_syn_ack   (w_syn_ack),
        .o_to_pulse  (o_to_pulse),
        .o_to_sticky (o_to_sticky)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ARB_IDLE;
            r_last  <= 1'b1;
            r_gnt   <= 2'b00;
        end else begin
            unique case (r_state)
                ARB_IDLE: begin
                    if (i_m0_cyc && (!i_m1_cyc || r_last)) begin
                        r_state <= ARB_GNT0;
                        r_gnt   <= 2'b01;
                    end else if (i_m1_cyc) begin
                        r_state <= ARB_GNT1;
                        r_gnt   <= 2'b10;
                    end
                end
                ARB_GNT0: begin
                    if (!i_m0_cyc) begin
                        r_last  <= 1'b0;
                        r_state <= i_m1_cyc ? ARB_GNT1 : ARB_IDLE;
                        r_gnt   <= i_m1_cyc ? 2'b10 : 2'b00;
                    end
                end
                ARB_GNT1: begin
                    if (!i_m1_cyc) begin
                        r_last  <= 1'b1;
                        r_state <= i_m0_cyc ? ARB_GNT0 : ARB_IDLE;
                        r_gnt   <= i_m0_cyc ? 2'b01 : 2'b00;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_gnt   <= 2'b00;
                end
            endcase
        end
    end
endmodule
